// File: rtl/kernel_launcher.sv
// kernel_launcher: host command sequencer in front of the gpu top.
// It takes one command per valid/ready handshake, drives the program
// memory, data memory, device control register or kernel start, and
// returns exactly one response word per command. Every output comes
// straight from a flop.
module kernel_launcher #(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   // host command channel
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [2:0]           cmd_op,
   input  logic [ADDR_BITS-1:0] cmd_addr,
   input  logic [DATA_BITS-1:0] cmd_data,
   // host response channel
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [DATA_BITS-1:0] rsp_data,
   output logic                 rsp_error,
   // program memory write port
   output logic                 prog_write_valid,
   output logic [ADDR_BITS-1:0] prog_write_address,
   output logic [DATA_BITS-1:0] prog_write_data,
   input  logic                 prog_write_ready,
   // data memory write port
   output logic                 data_write_valid,
   output logic [ADDR_BITS-1:0] data_write_address,
   output logic [DATA_BITS-1:0] data_write_data,
   input  logic                 data_write_ready,
   // data memory read port
   output logic                 data_read_valid,
   output logic [ADDR_BITS-1:0] data_read_address,
   input  logic                 data_read_ready,
   input  logic [DATA_BITS-1:0] data_read_data,
   // device control register and kernel execution
   output logic                 device_control_write_enable,
   output logic [7:0]           device_control_data,
   output logic                 start,
   input  logic                 done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PROG_WR,
      S_DATA_WR,
      S_DCR_WR,
      S_RUN,
      S_DATA_RD,
      S_RESP
   } state_t;

   localparam logic [2:0] OP_WRITE_PROG  = 3'd0;
   localparam logic [2:0] OP_WRITE_DATA  = 3'd1;
   localparam logic [2:0] OP_SET_THREADS = 3'd2;
   localparam logic [2:0] OP_LAUNCH      = 3'd3;
   localparam logic [2:0] OP_READ_DATA   = 3'd4;

   localparam logic [DATA_BITS-1:0] ALL_ONES = {DATA_BITS{1'b1}};

   state_t               state_q, state_d;
   logic                 threads_set_q, threads_set_d;
   logic [DATA_BITS-1:0] count_q, count_d;
   logic                 cmd_ready_q, cmd_ready_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [DATA_BITS-1:0] rsp_data_q, rsp_data_d;
   logic                 rsp_error_q, rsp_error_d;
   logic                 pw_valid_q, pw_valid_d;
   logic [ADDR_BITS-1:0] pw_addr_q, pw_addr_d;
   logic [DATA_BITS-1:0] pw_data_q, pw_data_d;
   logic                 dw_valid_q, dw_valid_d;
   logic [ADDR_BITS-1:0] dw_addr_q, dw_addr_d;
   logic [DATA_BITS-1:0] dw_data_q, dw_data_d;
   logic                 dr_valid_q, dr_valid_d;
   logic [ADDR_BITS-1:0] dr_addr_q, dr_addr_d;
   logic                 dcr_we_q, dcr_we_d;
   logic [7:0]           dcr_data_q, dcr_data_d;
   logic                 start_q, start_d;

   // Next-state and next-output logic for the command sequencer.
   always_comb begin
      // NOTE: every _d starts from its _q (or a pulse default) so no path leaves it unassigned and no latch is inferred.
      state_d       = state_q;
      threads_set_d = threads_set_q;
      count_d       = count_q;
      cmd_ready_d   = cmd_ready_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_data_d    = rsp_data_q;
      rsp_error_d   = rsp_error_q;
      pw_valid_d    = pw_valid_q;
      pw_addr_d     = pw_addr_q;
      pw_data_d     = pw_data_q;
      dw_valid_d    = dw_valid_q;
      dw_addr_d     = dw_addr_q;
      dw_data_d     = dw_data_q;
      dr_valid_d    = dr_valid_q;
      dr_addr_d     = dr_addr_q;
      dcr_we_d      = 1'b0;
      dcr_data_d    = dcr_data_q;
      start_d       = start_q;

      case (state_q)
         S_IDLE: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               // Default payload is the command data echo; ops that return
               // something else overwrite it before rsp_valid rises.
               rsp_data_d  = cmd_data;
               rsp_error_d = 1'b0;
               case (cmd_op)
                  OP_WRITE_PROG: begin
                     state_d    = S_PROG_WR;
                     pw_valid_d = 1'b1;
                     pw_addr_d  = cmd_addr;
                     pw_data_d  = cmd_data;
                  end
                  OP_WRITE_DATA: begin
                     state_d    = S_DATA_WR;
                     dw_valid_d = 1'b1;
                     dw_addr_d  = cmd_addr;
                     dw_data_d  = cmd_data;
                  end
                  OP_SET_THREADS: begin
                     state_d    = S_DCR_WR;
                     dcr_we_d   = 1'b1;
                     dcr_data_d = cmd_data[7:0];
                  end
                  OP_LAUNCH: begin
                     if (threads_set_q) begin
                        state_d = S_RUN;
                        start_d = 1'b1;
                        count_d = '0;
                     end else begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = ALL_ONES;
                        rsp_error_d = 1'b1;
                     end
                  end
                  OP_READ_DATA: begin
                     state_d    = S_DATA_RD;
                     dr_valid_d = 1'b1;
                     dr_addr_d  = cmd_addr;
                  end
                  default: begin
                     state_d     = S_RESP;
                     rsp_valid_d = 1'b1;
                     rsp_data_d  = '0;
                     rsp_error_d = 1'b1;
                  end
               endcase
            end
         end
         S_PROG_WR: begin
            if (prog_write_ready) begin
               pw_valid_d  = 1'b0;
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
            end
         end
         S_DATA_WR: begin
            if (data_write_ready) begin
               dw_valid_d  = 1'b0;
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
            end
         end
         S_DCR_WR: begin
            threads_set_d = |dcr_data_q;
            state_d       = S_RESP;
            rsp_valid_d   = 1'b1;
         end
         S_RUN: begin
            if (done) begin
               start_d     = 1'b0;
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_data_d  = count_q;
            end else if (count_q != ALL_ONES) begin
               count_d = count_q + 1'b1;
            end
         end
         S_DATA_RD: begin
            if (data_read_ready) begin
               dr_valid_d  = 1'b0;
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_data_d  = data_read_data;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
               cmd_ready_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and registered outputs; reset clears everything immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the reset branch clears every flop, payload registers included, so all outputs read 0 during reset.
         state_q       <= S_IDLE;
         threads_set_q <= 1'b0;
         count_q       <= '0;
         cmd_ready_q   <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_data_q    <= '0;
         rsp_error_q   <= 1'b0;
         pw_valid_q    <= 1'b0;
         pw_addr_q     <= '0;
         pw_data_q     <= '0;
         dw_valid_q    <= 1'b0;
         dw_addr_q     <= '0;
         dw_data_q     <= '0;
         dr_valid_q    <= 1'b0;
         dr_addr_q     <= '0;
         dcr_we_q      <= 1'b0;
         dcr_data_q    <= '0;
         start_q       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
         state_q       <= state_d;
         threads_set_q <= threads_set_d;
         count_q       <= count_d;
         cmd_ready_q   <= cmd_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
         rsp_error_q   <= rsp_error_d;
         pw_valid_q    <= pw_valid_d;
         pw_addr_q     <= pw_addr_d;
         pw_data_q     <= pw_data_d;
         dw_valid_q    <= dw_valid_d;
         dw_addr_q     <= dw_addr_d;
         dw_data_q     <= dw_data_d;
         dr_valid_q    <= dr_valid_d;
         dr_addr_q     <= dr_addr_d;
         dcr_we_q      <= dcr_we_d;
         dcr_data_q    <= dcr_data_d;
         start_q       <= start_d;
      end
   end

   assign cmd_ready                   = cmd_ready_q;
   assign rsp_valid                   = rsp_valid_q;
   assign rsp_data                    = rsp_data_q;
   assign rsp_error                   = rsp_error_q;
   assign prog_write_valid            = pw_valid_q;
   assign prog_write_address          = pw_addr_q;
   assign prog_write_data             = pw_data_q;
   assign data_write_valid            = dw_valid_q;
   assign data_write_address          = dw_addr_q;
   assign data_write_data             = dw_data_q;
   assign data_read_valid             = dr_valid_q;
   assign data_read_address           = dr_addr_q;
   assign device_control_write_enable = dcr_we_q;
   assign device_control_data         = dcr_data_q;
   assign start                       = start_q;

endmodule

// File: tb/tb_kernel_launcher.sv
// Testbench for kernel_launcher: plays host, memories and gpu, and compares
// every response against a command-level reference model.
module tb_kernel_launcher;

   localparam int AB = 8;
   localparam int DB = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid, cmd_ready;
   logic [2:0]    cmd_op;
   logic [AB-1:0] cmd_addr;
   logic [DB-1:0] cmd_data;
   logic          rsp_valid, rsp_ready, rsp_error;
   logic [DB-1:0] rsp_data;
   logic          prog_write_valid, prog_write_ready;
   logic [AB-1:0] prog_write_address;
   logic [DB-1:0] prog_write_data;
   logic          data_write_valid, data_write_ready;
   logic [AB-1:0] data_write_address;
   logic [DB-1:0] data_write_data;
   logic          data_read_valid, data_read_ready;
   logic [AB-1:0] data_read_address;
   logic [DB-1:0] data_read_data;
   logic          device_control_write_enable;
   logic [7:0]    device_control_data;
   logic          start, done;

   always #5 clk = ~clk;

   kernel_launcher #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
      .clk                         (clk),
      .reset                       (reset),
      .cmd_valid                   (cmd_valid),
      .cmd_ready                   (cmd_ready),
      .cmd_op                      (cmd_op),
      .cmd_addr                    (cmd_addr),
      .cmd_data                    (cmd_data),
      .rsp_valid                   (rsp_valid),
      .rsp_ready                   (rsp_ready),
      .rsp_data                    (rsp_data),
      .rsp_error                   (rsp_error),
      .prog_write_valid            (prog_write_valid),
      .prog_write_address          (prog_write_address),
      .prog_write_data             (prog_write_data),
      .prog_write_ready            (prog_write_ready),
      .data_write_valid            (data_write_valid),
      .data_write_address          (data_write_address),
      .data_write_data             (data_write_data),
      .data_write_ready            (data_write_ready),
      .data_read_valid             (data_read_valid),
      .data_read_address           (data_read_address),
      .data_read_ready             (data_read_ready),
      .data_read_data              (data_read_data),
      .device_control_write_enable (device_control_write_enable),
      .device_control_data         (device_control_data),
      .start                       (start),
      .done                        (done)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Memory devices as seen through the DUT's write ports.
   logic [DB-1:0] prog_store [256];
   logic [DB-1:0] mem_store  [256];
   // Reference model state, updated from the command stream only.
   logic [DB-1:0] model_mem  [256];
   bit            threads_model;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Inputs the DUT must ignore in its current state get random values.
   task automatic scramble_inputs();
      done             = 1'($urandom);
      prog_write_ready = 1'($urandom);
      data_write_ready = 1'($urandom);
      data_read_ready  = 1'($urandom);
      data_read_data   = 16'($urandom);
   endtask

   // Present a command and return at the negedge of the cycle after acceptance.
   task automatic send_cmd(input logic [2:0] op, input logic [7:0] addr, input logic [15:0] data);
      int guard = 0;
      cmd_op    = op;
      cmd_addr  = addr;
      cmd_data  = data;
      cmd_valid = 1'b1;
      while (cmd_ready !== 1'b1 && guard < 100) begin
         scramble_inputs();
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) check("cmd_accept_timeout", 32'(guard), 32'd0);
      scramble_inputs();
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op    = 3'($urandom);
      cmd_addr  = 8'($urandom);
      cmd_data  = 16'($urandom);
   endtask

   // Run one command end to end and compare against the reference model.
   task automatic do_cmd(input logic [2:0] op, input logic [7:0] addr, input logic [15:0] data,
                         input int stall, input int run_len, input int hold);
      int            cyc = 0;
      int            n_pw = 0, n_dw = 0, n_dr = 0, n_we = 0, n_st = 0;
      int            e_pw = 0, e_dw = 0, e_dr = 0, e_we = 0, e_st = 0;
      int            bad = 0;
      int            exp_lat = -1;
      logic [15:0]   exp_rsp;
      logic          exp_err;
      logic [7:0]    dcr_seen = 8'h00;

      exp_rsp = data;
      exp_err = 1'b0;
      case (op)
         3'd0: begin e_pw = stall + 1; exp_lat = stall + 1; end
         3'd1: begin e_dw = stall + 1; exp_lat = stall + 1; model_mem[addr] = data; end
         3'd2: begin e_we = 1; exp_lat = 1; end
         3'd3: begin
            if (threads_model) begin
               e_st = run_len + 1; exp_lat = run_len + 1; exp_rsp = 16'(run_len);
            end else begin
               exp_rsp = 16'hFFFF; exp_err = 1'b1;
            end
         end
         3'd4: begin e_dr = stall + 1; exp_lat = stall + 1; exp_rsp = model_mem[addr]; end
         default: begin exp_rsp = 16'h0000; exp_err = 1'b1; end
      endcase

      rsp_ready = 1'b0;
      send_cmd(op, addr, data);

      while (rsp_valid !== 1'b1 && cyc < 200) begin
         scramble_inputs();
         if (prog_write_valid) begin
            n_pw++;
            if (prog_write_address !== addr || prog_write_data !== data) bad++;
         end
         if (data_write_valid) begin
            n_dw++;
            if (data_write_address !== addr || data_write_data !== data) bad++;
         end
         if (data_read_valid) begin
            n_dr++;
            if (data_read_address !== addr) bad++;
         end
         if (device_control_write_enable) begin
            n_we++;
            dcr_seen = device_control_data;
         end
         if (start) n_st++;
         case (op)
            3'd0: prog_write_ready = (cyc >= stall);
            3'd1: data_write_ready = (cyc >= stall);
            3'd3: done = (cyc == run_len);
            3'd4: begin
               data_read_ready = (cyc >= stall);
               if (data_read_ready) data_read_data = mem_store[addr];
            end
            default: ;
         endcase
         if (prog_write_valid && prog_write_ready) prog_store[prog_write_address] = prog_write_data;
         if (data_write_valid && data_write_ready) mem_store[data_write_address] = data_write_data;
         @(negedge clk);
         cyc++;
      end

      check("rsp_timeout", 32'(cyc < 200), 32'd1);
      if (exp_lat >= 0) check("latency", 32'(cyc), 32'(exp_lat));
      check("rsp_data", 32'(rsp_data), 32'(exp_rsp));
      check("rsp_error", 32'(rsp_error), 32'(exp_err));
      check("prog_valid_cycles", 32'(n_pw), 32'(e_pw));
      check("data_wr_valid_cycles", 32'(n_dw), 32'(e_dw));
      check("data_rd_valid_cycles", 32'(n_dr), 32'(e_dr));
      check("dcr_pulses", 32'(n_we), 32'(e_we));
      check("start_cycles", 32'(n_st), 32'(e_st));
      check("port_payload_stable", 32'(bad), 32'd0);
      check("start_low_in_resp", 32'(start), 32'd0);
      if (op == 3'd0) check("prog_mem_written", 32'(prog_store[addr]), 32'(data));
      if (op == 3'd1) check("data_mem_written", 32'(mem_store[addr]), 32'(data));
      if (op == 3'd2) begin
         check("dcr_data", 32'(dcr_seen), 32'(data[7:0]));
         threads_model = (data[7:0] != 8'h00);
      end

      bad = 0;
      for (int i = 0; i < hold; i++) begin
         scramble_inputs();
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_data !== exp_rsp || rsp_error !== exp_err || cmd_ready !== 1'b0)
            bad++;
      end
      check("rsp_hold_stable", 32'(bad), 32'd0);
      rsp_ready = 1'b1;
      scramble_inputs();
      @(negedge clk);
      rsp_ready = 1'b0;
      check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
      check("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      int   bad;
      logic any_out;
      int   r;
      logic [2:0]  op;
      logic [15:0] d;

      for (int i = 0; i < 256; i++) begin
         prog_store[i] = '0;
         mem_store[i]  = '0;
         model_mem[i]  = '0;
      end
      threads_model    = 1'b0;
      reset            = 1'b0;
      cmd_valid        = 1'b1;
      cmd_op           = 3'd0;
      cmd_addr         = 8'h55;
      cmd_data         = 16'h1234;
      rsp_ready        = 1'b1;
      prog_write_ready = 1'b1;
      data_write_ready = 1'b1;
      data_read_ready  = 1'b1;
      data_read_data   = 16'hABCD;
      done             = 1'b1;

      // Reset with a command pending: every output must be 0.
      repeat (3) @(negedge clk);
      any_out = |{cmd_ready, rsp_valid, rsp_data, rsp_error, prog_write_valid, prog_write_address,
                  prog_write_data, data_write_valid, data_write_address, data_write_data,
                  data_read_valid, data_read_address, device_control_write_enable,
                  device_control_data, start};
      check("reset_outputs_zero", 32'(any_out), 32'd0);
      reset     = 1'b1;
      rsp_ready = 1'b0;
      @(negedge clk);
      check("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);
      check("start_after_reset", 32'(start), 32'd0);
      cmd_valid = 1'b0;

      // Directed sequence.
      do_cmd(3'd0, 8'h03, 16'h50A1, 3, 0, 0);
      do_cmd(3'd1, 8'hFF, 16'h50A1, 3, 0, 0);
      do_cmd(3'd3, 8'h00, 16'h0000, 0, 0, 0);
      do_cmd(3'd6, 8'h00, 16'h1111, 0, 0, 0);
      do_cmd(3'd2, 8'h00, 16'h0008, 0, 0, 0);
      do_cmd(3'd3, 8'h00, 16'h0000, 0, 20, 0);
      do_cmd(3'd1, 8'h10, 16'h7FFF, 0, 0, 0);
      do_cmd(3'd4, 8'h10, 16'h0000, 2, 0, 5);

      // Reset in the middle of a kernel run.
      do_cmd(3'd2, 8'h00, 16'h0008, 0, 0, 0);
      rsp_ready = 1'b0;
      send_cmd(3'd3, 8'h00, 16'h0000);
      check("start_on_launch", 32'(start), 32'd1);
      for (int i = 0; i < 5; i++) begin
         done = 1'b0;
         @(negedge clk);
      end
      #2 reset = 1'b0;
      #1;
      check("start_async_drop", 32'(start), 32'd0);
      check("rsp_valid_in_reset", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         done = 1'b1;
         rsp_ready = 1'b0;
         @(negedge clk);
         if (rsp_valid !== 1'b0 || start !== 1'b0) bad++;
      end
      check("no_rsp_after_reset", 32'(bad), 32'd0);
      threads_model = 1'b0;
      do_cmd(3'd3, 8'h00, 16'h0000, 0, 5, 0);

      // Randomized command stream.
      for (int n = 0; n < 60; n++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1:    op = 3'd0;
            2, 3:    op = 3'd1;
            4:       op = 3'd2;
            5, 6:    op = 3'd3;
            7, 8:    op = 3'd4;
            default: op = 3'($urandom_range(5, 7));
         endcase
         d = 16'($urandom);
         if (op == 3'd2 && $urandom_range(0, 3) == 0) d = 16'h0000;
         do_cmd(op, 8'($urandom_range(0, 15)), d, $urandom_range(0, 3),
                $urandom_range(0, 15), $urandom_range(0, 2));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/kernel_launcher.md
# kernel_launcher

Host-side command sequencer directly upstream of the `gpu` top. It accepts a stream of host commands and performs the matching action:
- writes program memory and data memory over single-channel write ports;
- programs the device control register (thread count);
- launches a kernel and measures its run length;
- reads back data memory.

Every command returns exactly one response word, so the host, or a testbench, can drive a complete kernel run through one valid/ready pair.

## Interface
- `ADDR_BITS`, 8: program and data memory address width.
- `DATA_BITS`, 16: data word width (Q1.15). Also the program instruction width, `cmd_data` width and `rsp_data` width.
- `clk` in 1: clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset (0 = reset).
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_op` in 3: 0 WRITE_PROG, 1 WRITE_DATA, 2 SET_THREADS, 3 LAUNCH, 4 READ_DATA, 5–7 illegal.
- `cmd_addr` in ADDR_BITS / `cmd_data` in DATA_BITS: command operands.
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_data` out DATA_BITS / `rsp_error` out 1: response payload and error flag.
- `prog_write_valid` out 1, `prog_write_address` out ADDR_BITS, `prog_write_data` out DATA_BITS, `prog_write_ready` in 1: program memory write port.
- `data_write_valid` out 1, `data_write_address` out ADDR_BITS, `data_write_data` out DATA_BITS, `data_write_ready` in 1: data memory write port.
- `data_read_valid` out 1, `data_read_address` out ADDR_BITS, `data_read_ready` in 1, `data_read_data` in DATA_BITS: data memory read port.
- `device_control_write_enable` out 1, `device_control_data` out 8: drive the gpu DCR.
- `start` out 1 / `done` in 1: gpu kernel execution.

## Operation
- States: IDLE, PROG_WR, DATA_WR, DCR_WR, RUN, DATA_RD, RESP.
- `cmd_ready` = 1 only in IDLE. A command is captured (op, addr, data) on `cmd_valid & cmd_ready`.
- WRITE_PROG → PROG_WR:
  - hold `prog_write_valid`, address and data until `prog_write_ready` is sampled high;
  - then → RESP with `rsp_data` = `cmd_data` echo, `rsp_error` = 0.
- WRITE_DATA → DATA_WR: identical, on the data write port.
- SET_THREADS → DCR_WR:
  - one-cycle `device_control_write_enable` with `device_control_data` = `cmd_data[7:0]`;
  - set internal `threads_set` flag if that value is nonzero, clear it if zero;
  - → RESP, echo, no error.
- LAUNCH:
  - if `threads_set` = 0: → RESP, `rsp_data` = 16'hFFFF, `rsp_error` = 1, `start` never asserted;
  - else → RUN: `start` = 1, cycle counter cleared to 0. Counter increments each RUN cycle in which `done` = 0 and saturates at all-ones.
  - When `done` is sampled 1: → RESP with `rsp_data` = counter, error 0.
- READ_DATA → DATA_RD:
  - hold `data_read_valid`/address until `data_read_ready` is sampled high;
  - capture `data_read_data` that cycle; → RESP with captured word.
- Illegal op: → RESP, `rsp_data` = 0, `rsp_error` = 1.
- RESP: `rsp_valid` = 1 with payload stable until `rsp_ready`; then → IDLE.
- `done` is ignored outside RUN. Memory ready inputs are ignored outside their own state.

## Timing
- Reset values (async, immediate): every output 0, including `cmd_ready`. State IDLE, `threads_set` = 0, counter 0. `cmd_ready` rises in the first cycle after reset releases.
- Command accepted at edge N: the state's outputs are valid from cycle N+1.
- Write/read with ready already high at N+1: `rsp_valid` at N+2. Each extra stall cycle adds one.
- SET_THREADS: write-enable pulse exactly in cycle N+1; `rsp_valid` at N+2.
- LAUNCH:
  - `start` high from N+1 through the cycle in which `done` is first sampled high (cycle M);
  - `start` low and `rsp_valid` high at M+1;
  - `rsp_data` = M−(N+1), saturated.
- Response accepted at edge R: `cmd_ready` = 1 at R+1. Peak throughput is one command per 3 cycles.
- All outputs are registered; no combinational path from any input to any output.
- `reset` asserted mid-operation (including RUN) drops `start` and all valids immediately. The pending response is discarded.

## Test plan
- Reset: assert reset with `cmd_valid` = 1 → all outputs 0. Release → `cmd_ready` = 1 next cycle, `start` = 0.
- Writes: WRITE_PROG addr 8'h03 data 16'h50A1, `prog_write_ready` held 0 for 3 cycles → valid/addr/data stable 4 cycles. Response 16'h50A1, no error. Repeat on the data port, addr 8'hFF.
- LAUNCH with no SET_THREADS → error response 16'hFFFF, `start` never high. Illegal op 6 → `rsp_error` = 1, data 0.
- Kernel run: SET_THREADS 8 → one-cycle DCR write of 8'h08. LAUNCH; model raises `done` 20 cycles after `start` → `start` high exactly 21 cycles, response 16'd20.
- Readback: READ_DATA addr 8'h10, memory returns 16'h7FFF after 2 stall cycles → `rsp_data` 16'h7FFF. `rsp_ready` held low 5 cycles → response held stable, `cmd_ready` stays 0.
- Mid-run reset: reset during RUN → `start` drops asynchronously, no response after release, `threads_set` cleared (next LAUNCH errors).
